// File: rtl/mem_arbiter.sv
// N-channel arbiter sharing one single-port memory slave between byte-access masters.
// Round-robin or fixed-priority grant, one transfer at a time, with a ready timeout that returns an error ack.
module mem_arbiter #(
    parameter int CHANNELS = 3,
    parameter int AW       = 26,
    parameter int DW       = 8,
    parameter int MODE     = 0,
    parameter int TIMEOUT  = 255
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [CHANNELS-1:0]    ch_req,
    input  logic [CHANNELS-1:0]    ch_we,
    input  logic [CHANNELS*AW-1:0] ch_address,
    input  logic [CHANNELS*DW-1:0] ch_wdata,
    output logic [CHANNELS-1:0]    ch_ack,
    output logic                   ch_err,
    output logic [DW-1:0]          ch_rdata,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [AW-1:0]          mem_address,
    output logic [DW-1:0]          mem_wdata,
    input  logic [DW-1:0]          mem_rdata,
    input  logic                   mem_ready
);

    localparam int              PW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int              TW   = $clog2(TIMEOUT + 1);
    localparam logic [PW:0]     NCH  = (PW + 1)'(CHANNELS);
    localparam logic [PW-1:0]   LAST = PW'(CHANNELS - 1);
    localparam logic [TW-1:0]   TMAX = TW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t              state;
    logic [PW-1:0]       rr_ptr;
    logic [PW-1:0]       grant;
    logic [PW-1:0]       winner;
    logic                found;
    logic [PW:0]         scan;
    logic [TW-1:0]       timer;
    logic                sel_we;
    logic [AW-1:0]       sel_address;
    logic [DW-1:0]       sel_wdata;
    logic [CHANNELS-1:0] grant_oh;

    // Scan order starts at rr_ptr (round-robin) or at 0 (fixed priority); first requester wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        scan   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (MODE == 0) begin
                scan = {1'b0, rr_ptr} + (PW + 1)'(i);
                if (scan >= NCH) scan = scan - NCH;
            end else begin
                scan = (PW + 1)'(i);
            end
            if (!found && ch_req[scan[PW-1:0]]) begin
                found  = 1'b1;
                winner = scan[PW-1:0];
            end
        end
    end

    always_comb begin
        sel_we      = 1'b0;
        sel_address = '0;
        sel_wdata   = '0;
        grant_oh    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (winner == PW'(i)) begin
                sel_we      = ch_we[i];
                sel_address = ch_address[i*AW +: AW];
                sel_wdata   = ch_wdata[i*DW +: DW];
            end
            grant_oh[i] = (grant == PW'(i));
        end
    end

    // Handshake: mem_req is a level held from ISSUE through the last WAIT cycle with mem_* stable;
    // the slave answers with a mem_ready level, which is only honoured in WAIT. The master sees a
    // single-cycle ch_ack (with ch_err) in DONE; ch_req is a level sampled only in IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant       <= '0;
            timer       <= '0;
            ch_ack      <= '0;
            ch_err      <= 1'b0;
            ch_rdata    <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant       <= winner;
                        mem_we      <= sel_we;
                        mem_address <= sel_address;
                        mem_wdata   <= sel_wdata;
                        mem_req     <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (mem_ready) begin
                        if (!mem_we) ch_rdata <= mem_rdata;
                        ch_err  <= 1'b0;
                        ch_ack  <= grant_oh;
                        mem_req <= 1'b0;
                        state   <= DONE;
                    end else if (timer == TMAX) begin
                        ch_err  <= 1'b1;
                        ch_ack  <= grant_oh;
                        mem_req <= 1'b0;
                        state   <= DONE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                DONE: begin
                    ch_ack <= '0;
                    ch_err <= 1'b0;
                    if (MODE == 0) rr_ptr <= (grant == LAST) ? '0 : grant + PW'(1);
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin and a fixed-priority instance, each with a
// latency-programmable slave model; single-transfer vector table plus multi-cycle sequences.
module tb_mem_arbiter;

    localparam int CH    = 3;
    localparam int AW    = 26;
    localparam int DW    = 8;
    localparam int NEVER = 1000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // round-robin instance signals
    logic [CH-1:0]    req_r = '0, we_r = '0, ack_r;
    logic [CH*AW-1:0] addr_r = '0;
    logic [CH*DW-1:0] wdata_r = '0;
    logic             err_r, mreq_r, mwe_r;
    logic [DW-1:0]    rdata_r, mwdata_r;
    logic [AW-1:0]    maddr_r;
    logic [DW-1:0]    mrdata_r = '0;
    logic             mready_r = 1'b0;

    // fixed-priority instance signals
    logic [CH-1:0]    req_f = '0, we_f = '0, ack_f;
    logic [CH*AW-1:0] addr_f = '0;
    logic [CH*DW-1:0] wdata_f = '0;
    logic             err_f, mreq_f, mwe_f;
    logic [DW-1:0]    rdata_f, mwdata_f;
    logic [AW-1:0]    maddr_f;
    logic [DW-1:0]    mrdata_f = '0;
    logic             mready_f = 1'b0;

    mem_arbiter #(.CHANNELS(CH), .AW(AW), .DW(DW), .MODE(0), .TIMEOUT(8)) u_rr (
        .clock(clock), .reset(reset), .ch_req(req_r), .ch_we(we_r), .ch_address(addr_r),
        .ch_wdata(wdata_r), .ch_ack(ack_r), .ch_err(err_r), .ch_rdata(rdata_r),
        .mem_req(mreq_r), .mem_we(mwe_r), .mem_address(maddr_r), .mem_wdata(mwdata_r),
        .mem_rdata(mrdata_r), .mem_ready(mready_r)
    );

    mem_arbiter #(.CHANNELS(CH), .AW(AW), .DW(DW), .MODE(1), .TIMEOUT(8)) u_fp (
        .clock(clock), .reset(reset), .ch_req(req_f), .ch_we(we_f), .ch_address(addr_f),
        .ch_wdata(wdata_f), .ch_ack(ack_f), .ch_err(err_f), .ch_rdata(rdata_f),
        .mem_req(mreq_f), .mem_we(mwe_f), .mem_address(maddr_f), .mem_wdata(mwdata_f),
        .mem_rdata(mrdata_f), .mem_ready(mready_f)
    );

    // Slave models: ready (level) once mem_req has been high for more than dly cycles.
    int            cnt_r = 0, dly_r = 1, cnt_f = 0, dly_f = 1;
    logic [DW-1:0] srd_r = '0, srd_f = '0;

    always @(negedge clock) begin
        if (mreq_r) cnt_r = cnt_r + 1; else cnt_r = 0;
        mready_r = mreq_r && (cnt_r > dly_r);
        mrdata_r = mready_r ? srd_r : '0;
        if (mreq_f) cnt_f = cnt_f + 1; else cnt_f = 0;
        mready_f = mreq_f && (cnt_f > dly_f);
        mrdata_f = mready_f ? srd_f : '0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            chk("ack_onehot_rr", {31'd0, $onehot0(ack_r) && !(err_r && ack_r == '0)}, 32'd1);
            chk("ack_onehot_fp", {31'd0, $onehot0(ack_f) && !(err_f && ack_f == '0)}, 32'd1);
        end
    end

    typedef struct {
        int            ch;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            dly;
        logic [DW-1:0] srd;
        int            lat;
        logic [DW-1:0] exp_rd;
        logic          exp_err;
    } vec_t;

    vec_t vecs[8];

    // One transfer on the round-robin instance; request and channel inputs are scrambled once in WAIT.
    task automatic run_vec(input vec_t v);
        int   c0, rise, hi;
        logic hold_ok, got;
        dly_r = v.dly;
        srd_r = v.srd;
        req_r = '0; we_r = '0; addr_r = '0; wdata_r = '0;
        req_r[v.ch] = 1'b1;
        we_r[v.ch] = v.we;
        addr_r[v.ch*AW +: AW] = v.addr;
        wdata_r[v.ch*DW +: DW] = v.wdata;
        c0 = cyc; rise = -1; hi = 0; hold_ok = 1'b1; got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clock);
            if (mreq_r) begin
                hi++;
                if (rise < 0) rise = cyc;
                if (mwe_r !== v.we || maddr_r !== v.addr || mwdata_r !== v.wdata) hold_ok = 1'b0;
                if (hi == 2) begin
                    req_r = '0; we_r = ~we_r; addr_r = ~addr_r; wdata_r = ~wdata_r;
                end
            end
            if (ack_r != '0) begin
                got = 1'b1;
                chk("vec_ack", 32'(ack_r), 32'(1) << v.ch);
                chk("vec_err", 32'(err_r), 32'(v.exp_err));
                chk("vec_rdata", 32'(rdata_r), 32'(v.exp_rd));
                chk("vec_issue_lat", 32'(rise - c0), 32'd1);
                chk("vec_ack_lat", 32'(cyc - rise), 32'(v.lat));
                chk("vec_req_high", 32'(hi), 32'(v.lat));
                chk("vec_hold", 32'(hold_ok), 32'd1);
            end
        end
        chk("vec_got_ack", 32'(got), 32'd1);
        req_r = '0; we_r = '0; addr_r = '0; wdata_r = '0;
        @(negedge clock);
        chk("vec_ack_pulse", {23'd0, ack_r, err_r, mreq_r}, 32'd0);
    endtask

    logic [CH-1:0] exp_q[$];

    initial begin : main
        int prev, low, rises, nacks, hi;
        logic [CH-1:0] e;
        logic got;
        vec_t v;

        // ch, we, addr, wdata, dly, srd, lat, exp_rd, exp_err
        vecs[0] = '{0, 1'b0, 26'h0001234, 8'h00, 3,     8'hA5, 4,  8'hA5, 1'b0};
        vecs[1] = '{1, 1'b1, 26'h0000010, 8'h3C, 2,     8'h77, 3,  8'hA5, 1'b0};
        vecs[2] = '{2, 1'b0, 26'h3FFFFFF, 8'h00, 0,     8'h5A, 2,  8'h5A, 1'b0};
        vecs[3] = '{0, 1'b0, 26'h0000ABC, 8'h00, NEVER, 8'hEE, 10, 8'h5A, 1'b1};
        vecs[4] = '{1, 1'b0, 26'h1555555, 8'h00, 8,     8'hC3, 9,  8'hC3, 1'b0};
        vecs[5] = '{2, 1'b0, 26'h2AAAAAA, 8'h00, 9,     8'h96, 10, 8'h96, 1'b0};
        vecs[6] = '{2, 1'b1, 26'h0000007, 8'h81, NEVER, 8'h11, 10, 8'h96, 1'b1};
        vecs[7] = '{1, 1'b0, 26'h0000100, 8'h00, 1,     8'h5C, 2,  8'h5C, 1'b0};

        // reset state
        repeat (3) @(negedge clock);
        chk("rst_rr", {ack_r, err_r, rdata_r, mreq_r, mwe_r, mwdata_r}, 32'd0);
        chk("rst_rr_addr", 32'(maddr_r), 32'd0);
        chk("rst_fp", {ack_f, err_f, rdata_f, mreq_f, mwe_f, mwdata_f}, 32'd0);
        chk("rst_fp_addr", 32'(maddr_f), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // round-robin fairness with all three holding requests
        dly_r = 1; srd_r = 8'h42;
        for (int i = 0; i < CH; i++) addr_r[i*AW +: AW] = AW'(i + 1);
        req_r = '1;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(3'b001); exp_q.push_back(3'b010); exp_q.push_back(3'b100);
        end
        prev = 0; low = 0; rises = 0; nacks = 0;
        for (int n = 0; n < 200 && nacks < 6; n++) begin
            @(negedge clock);
            if (mreq_r) begin
                if (prev == 0) begin
                    if (rises > 0) chk("rr_gap", 32'(low), 32'd2);
                    rises++;
                end
                low = 0;
            end else begin
                low++;
            end
            prev = int'(mreq_r);
            if (ack_r != '0) begin
                e = exp_q.pop_front();
                chk("rr_order", 32'(ack_r), 32'(e));
                chk("rr_rdata", 32'(rdata_r), 32'h42);
                nacks++;
                if (nacks == 6) req_r = '0;
            end
        end
        chk("rr_count", 32'(nacks), 32'd6);
        addr_r = '0;
        repeat (3) @(negedge clock);

        // fixed priority: ch0 keeps winning until it lets go
        dly_f = 1; srd_f = 8'h24;
        req_f = 3'b101;
        exp_q.delete();
        exp_q.push_back(3'b001); exp_q.push_back(3'b001);
        exp_q.push_back(3'b001); exp_q.push_back(3'b100);
        nacks = 0;
        for (int n = 0; n < 200 && nacks < 4; n++) begin
            @(negedge clock);
            if (ack_f != '0) begin
                e = exp_q.pop_front();
                chk("fp_order", 32'(ack_f), 32'(e));
                nacks++;
                if (nacks == 3) req_f[0] = 1'b0;
                if (nacks == 4) req_f = '0;
            end
        end
        chk("fp_count", 32'(nacks), 32'd4);
        repeat (3) @(negedge clock);

        // reset during WAIT: pointer must be back at 0 afterwards
        run_vec(vecs[7]);
        dly_r = NEVER;
        req_r = 3'b100;
        hi = 0;
        for (int n = 0; n < 20 && hi < 3; n++) begin
            @(negedge clock);
            if (mreq_r) hi++;
        end
        chk("rst_mid_reached_wait", 32'(hi), 32'd3);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_mid_outputs", {ack_r, err_r, rdata_r, mreq_r, mwe_r, mwdata_r}, 32'd0);
        chk("rst_mid_addr", 32'(maddr_r), 32'd0);
        reset = 1'b0;
        dly_r = 1; srd_r = 8'hB7;
        req_r = 3'b110;
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clock);
            if (ack_r != '0) begin
                got = 1'b1;
                chk("rst_mid_first_grant", 32'(ack_r), 32'b010);
                chk("rst_mid_rdata", 32'(rdata_r), 32'hB7);
                req_r = '0;
            end
        end
        chk("rst_mid_got_ack", 32'(got), 32'd1);
        repeat (3) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
